// File: rtl/ppd_pkg.sv
// Purpose: shared constants and FSM state encoding for the power-ratio packet detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ppd_pkg;

    localparam int DEF_DATA_W      = 48;
    localparam int DEF_SAMPLE_W    = 12;
    localparam int DEF_SHORT_SHIFT = 3;
    localparam int DEF_LONG_SHIFT  = 8;
    localparam int DEF_PRE_DEPTH   = 16;
    localparam int DEF_ACC_W       = 32;

    // Threshold is unsigned Q8.8, so the short side of the compare is scaled by 2^8.
    localparam int Q_FRAC_BITS = 8;

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PASS    = 2'd2,
        ST_HOLDOFF = 2'd3
    } ppd_state_e;

endpackage

// File: rtl/ppd_delay_line.sv
// Purpose: circular pre-trigger buffer; dout is the word written DEPTH pushes ago.
// Latency: combinational read of the oldest entry, write on the push edge.
// Backpressure: none; every push overwrites the oldest entry.
// Ports: clk (rising edge), push (advance), din (sample in), dout (sample DEPTH pushes old).
module ppd_delay_line #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     ptr;

    // The slot about to be overwritten holds the oldest sample.
    assign dout = mem[ptr];

    // No reset: the detector's warmup period refills every slot before use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= din;
            ptr      <= ptr + AW'(1);
        end
    end

endmodule

// File: rtl/ppd_gen2.sv
// Purpose: short/long magnitude-average packet detector with pre-trigger capture and bypass.
// Latency: one cycle from fifo_in_wrreq to fifo_out_wrreq for every emitted sample.
// Backpressure: none; every fifo_in_wrreq cycle is accepted, output cannot stall.
// Ports: clk_clk/reset_reset_n (sync active-low), fifo_in_* sample stream, fifo_out_* emitted
//        stream, ppd_cfg_* lengths/threshold/controls, ppd_debug_* trigger count, sums, state.
module ppd_gen2
    import ppd_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int SHORT_SHIFT = DEF_SHORT_SHIFT,
    parameter int LONG_SHIFT  = DEF_LONG_SHIFT,
    parameter int PRE_DEPTH   = DEF_PRE_DEPTH,
    parameter int ACC_W       = DEF_ACC_W
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] fifo_in_wdata,
    input  logic              fifo_in_wrreq,
    output logic [DATA_W-1:0] fifo_out_wrdata,
    output logic              fifo_out_wrreq,
    input  logic [15:0]       ppd_cfg_passthrough_len,
    input  logic [15:0]       ppd_cfg_holdoff_len,
    input  logic [15:0]       ppd_cfg_threshold,
    input  logic              ppd_cfg_clear_rs,
    input  logic              ppd_cfg_enable,
    input  logic              ppd_cfg_bypass,
    output logic [31:0]       ppd_debug_count,
    output logic [31:0]       ppd_debug_long_sum,
    output logic [31:0]       ppd_debug_short_sum,
    output logic [1:0]        ppd_debug_state
);
    localparam int MAG_W = SAMPLE_W + 1;
    localparam int DSH   = LONG_SHIFT - SHORT_SHIFT;
    // Wide enough that neither side of the ratio compare can overflow.
    localparam int CMP_W = ACC_W + DSH + 16;

    ppd_state_e        state;
    logic [ACC_W-1:0]  s_acc, l_acc;
    logic [LONG_SHIFT-1:0] warm_cnt;
    logic [16:0]       pass_cnt;
    logic [15:0]       hold_cnt;

    logic [MAG_W-1:0]  ext_i, ext_q, abs_i, abs_q, mag;
    logic [ACC_W-1:0]  s_nxt, l_nxt;
    logic [CMP_W-1:0]  cmp_lhs, cmp_rhs;
    logic              trig, emit;
    logic [DATA_W-1:0] dl_out;

    // One extra bit so |-2^(SAMPLE_W-1)| is representable.
    assign ext_i = {fifo_in_wdata[SAMPLE_W-1], fifo_in_wdata[SAMPLE_W-1:0]};
    assign ext_q = {fifo_in_wdata[2*SAMPLE_W-1], fifo_in_wdata[2*SAMPLE_W-1:SAMPLE_W]};
    assign abs_i = ext_i[MAG_W-1] ? (~ext_i + MAG_W'(1)) : ext_i;
    assign abs_q = ext_q[MAG_W-1] ? (~ext_q + MAG_W'(1)) : ext_q;
    assign mag   = abs_i + abs_q;

    assign s_nxt = s_acc - (s_acc >> SHORT_SHIFT) + ACC_W'(mag);
    assign l_nxt = l_acc - (l_acc >> LONG_SHIFT) + ACC_W'(mag);

    // s is scaled up to l's time constant so both represent a mean magnitude.
    assign cmp_lhs = CMP_W'(s_acc) << (DSH + Q_FRAC_BITS);
    assign cmp_rhs = CMP_W'(l_acc) * CMP_W'(ppd_cfg_threshold);
    assign trig    = ppd_cfg_enable && (cmp_lhs > cmp_rhs);

    // The triggering sample already emits (its PRE_DEPTH-old partner).
    assign emit = fifo_in_wrreq && !ppd_cfg_clear_rs &&
                  ((state == ST_PASS) || ((state == ST_ARMED) && trig));

    ppd_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (PRE_DEPTH)
    ) u_dl (
        .clk  (clk_clk),
        .push (fifo_in_wrreq),
        .din  (fifo_in_wdata),
        .dout (dl_out)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state           <= ST_WARMUP;
            s_acc           <= '0;
            l_acc           <= '0;
            warm_cnt        <= '0;
            pass_cnt        <= '0;
            hold_cnt        <= '0;
            ppd_debug_count <= '0;
            fifo_out_wrreq  <= 1'b0;
            fifo_out_wrdata <= '0;
        end else begin
            // Output path: bypass overrides the detector's emission.
            fifo_out_wrreq <= 1'b0;
            if (ppd_cfg_bypass) begin
                fifo_out_wrreq <= fifo_in_wrreq;
                if (fifo_in_wrreq) begin
                    fifo_out_wrdata <= fifo_in_wdata;
                end
            end else if (emit) begin
                fifo_out_wrreq  <= 1'b1;
                fifo_out_wrdata <= dl_out;
            end

            if (ppd_cfg_clear_rs) begin
                state    <= ST_WARMUP;
                s_acc    <= '0;
                l_acc    <= '0;
                warm_cnt <= '0;
                pass_cnt <= '0;
                hold_cnt <= '0;
            end else if (fifo_in_wrreq) begin
                s_acc <= s_nxt;
                l_acc <= l_nxt;
                case (state)
                    ST_WARMUP: begin
                        if (&warm_cnt) begin
                            state <= ST_ARMED;
                        end else begin
                            warm_cnt <= warm_cnt + LONG_SHIFT'(1);
                        end
                    end
                    ST_ARMED: begin
                        if (trig) begin
                            state    <= ST_PASS;
                            // Samples still to emit after this one.
                            pass_cnt <= 17'(PRE_DEPTH) + 17'(ppd_cfg_passthrough_len) - 17'd1;
                            if (ppd_debug_count != 32'hFFFF_FFFF) begin
                                ppd_debug_count <= ppd_debug_count + 32'd1;
                            end
                        end
                    end
                    ST_PASS: begin
                        if (pass_cnt <= 17'd1) begin
                            hold_cnt <= ppd_cfg_holdoff_len;
                            state    <= (ppd_cfg_holdoff_len == 16'd0) ? ST_ARMED : ST_HOLDOFF;
                        end else begin
                            pass_cnt <= pass_cnt - 17'd1;
                        end
                    end
                    default: begin
                        if (hold_cnt <= 16'd1) begin
                            state <= ST_ARMED;
                        end else begin
                            hold_cnt <= hold_cnt - 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign ppd_debug_short_sum = 32'(s_acc);
    assign ppd_debug_long_sum  = 32'(l_acc);
    assign ppd_debug_state     = state;

endmodule

// File: tb/tb_ppd_gen2.sv
module tb_ppd_gen2;
    import ppd_pkg::*;

    localparam int PRE  = 16;
    localparam int NSTEP = 450;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [47:0] fifo_in_wdata = '0;
    logic        fifo_in_wrreq = 1'b0;
    logic [47:0] fifo_out_wrdata;
    logic        fifo_out_wrreq;
    logic [15:0] cfg_len = 16'd64, cfg_hold = 16'd100, cfg_thr = 16'h0200;
    logic        cfg_clr = 1'b0, cfg_en = 1'b1, cfg_byp = 1'b0;
    logic [31:0] dbg_cnt, dbg_l, dbg_s;
    logic [1:0]  dbg_st;

    always #5 clk_clk = ~clk_clk;

    ppd_gen2 dut (
        .clk_clk                 (clk_clk),
        .reset_reset_n           (reset_reset_n),
        .fifo_in_wdata           (fifo_in_wdata),
        .fifo_in_wrreq           (fifo_in_wrreq),
        .fifo_out_wrdata         (fifo_out_wrdata),
        .fifo_out_wrreq          (fifo_out_wrreq),
        .ppd_cfg_passthrough_len (cfg_len),
        .ppd_cfg_holdoff_len     (cfg_hold),
        .ppd_cfg_threshold       (cfg_thr),
        .ppd_cfg_clear_rs        (cfg_clr),
        .ppd_cfg_enable          (cfg_en),
        .ppd_cfg_bypass          (cfg_byp),
        .ppd_debug_count         (dbg_cnt),
        .ppd_debug_long_sum      (dbg_l),
        .ppd_debug_short_sum     (dbg_s),
        .ppd_debug_state         (dbg_st)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sample-indexed view of the detector.
    longint      m_s, m_l, m_cnt;
    int          m_n;          // accepted samples since reset/clear
    int          m_burst_end;  // first sample index after the current burst
    int          m_ready;      // first sample index allowed to trigger again
    logic [47:0] hist[$];      // every accepted sample, oldest first
    logic [47:0] out_log[$];   // words the DUT emitted
    logic [47:0] exp_log[$];   // words the model expected
    int          trig_log[$];  // global sample index of each DUT trigger
    int          g_acc = 0;
    logic [31:0] last_cnt = '0;

    function automatic int absv(input logic [11:0] x);
        logic signed [11:0] v;
        v = x;
        return (v < 0) ? -int'(v) : int'(v);
    endfunction

    function automatic int mstate(input int n);
        if (n < 256) return 0;
        if (n < m_burst_end) return 2;
        if (n < m_ready) return 3;
        return 1;
    endfunction

    function automatic logic [47:0] mk(input logic [23:0] hi, input int i, input int q);
        return {hi, 12'(q), 12'(i)};
    endfunction

    task automatic model_init();
        m_s = 0; m_l = 0; m_n = 0; m_cnt = 0; m_burst_end = 0; m_ready = 0;
        trig_log.delete();
        last_cnt = '0;
    endtask

    task automatic step(input bit vld, input logic [47:0] dat);
        bit          exp_vld;
        logic [47:0] exp_dat;
        int          st;
        longint      mag;
        @(negedge clk_clk);
        fifo_in_wrreq = vld;
        fifo_in_wdata = dat;
        exp_vld = 1'b0;
        exp_dat = '0;
        if (cfg_byp) begin
            exp_vld = vld;
            exp_dat = dat;
        end
        if (cfg_clr) begin
            m_s = 0; m_l = 0; m_n = 0; m_burst_end = 0; m_ready = 0;
        end else if (vld) begin
            st = mstate(m_n);
            if (st == 1 && cfg_en && ((m_s << 5) * 256 > m_l * longint'(cfg_thr))) begin
                m_burst_end = m_n + PRE + int'(cfg_len);
                m_ready     = m_burst_end;
                m_cnt++;
                st = 2;
            end
            if (st == 2) begin
                if (m_n == m_burst_end - 1) m_ready = m_burst_end + int'(cfg_hold);
                if (!cfg_byp) begin
                    exp_vld = 1'b1;
                    exp_dat = hist[hist.size() - PRE];
                end
            end
            mag = absv(dat[11:0]) + absv(dat[23:12]);
            m_s = (m_s - (m_s >> 3) + mag) & 64'hFFFF_FFFF;
            m_l = (m_l - (m_l >> 8) + mag) & 64'hFFFF_FFFF;
            m_n++;
        end
        if (vld) begin
            hist.push_back(dat);
            g_acc++;
        end
        @(posedge clk_clk);
        #1;
        check("out_vld", fifo_out_wrreq, exp_vld);
        if (exp_vld) check("out_dat", fifo_out_wrdata, exp_dat);
        check("short_sum", dbg_s, m_s);
        check("long_sum", dbg_l, m_l);
        check("trig_count", dbg_cnt, m_cnt);
        check("state", dbg_st, mstate(m_n));
        if (fifo_out_wrreq) out_log.push_back(fifo_out_wrdata);
        if (exp_vld) exp_log.push_back(exp_dat);
        if (dbg_cnt != last_cnt) trig_log.push_back(g_acc);
        last_cnt = dbg_cnt;
    endtask

    // Reset is held with live inputs and clear asserted, to show it dominates.
    task automatic do_reset();
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        fifo_in_wrreq = 1'b1;
        fifo_in_wdata = 48'h1234_5678_9ABC;
        cfg_clr       = 1'b1;
        repeat (2) @(posedge clk_clk);
        #1;
        check("rst_vld", fifo_out_wrreq, 0);
        check("rst_dat", fifo_out_wrdata, 0);
        check("rst_state", dbg_st, 0);
        check("rst_count", dbg_cnt, 0);
        check("rst_s", dbg_s, 0);
        check("rst_l", dbg_l, 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        cfg_clr       = 1'b0;
        fifo_in_wrreq = 1'b0;
        model_init();
    endtask

    logic [23:0] hi_tab[NSTEP];
    logic [47:0] seq_a[$];

    function automatic logic [47:0] step_word(input int idx);
        int a;
        a = (idx < 300) ? 50 : 500;
        return mk(hi_tab[idx], a, a);
    endfunction

    initial begin
        int          idx;
        bit          reached;
        logic [31:0] cnt_before;
        int          amp, iv, qv;

        for (int i = 0; i < NSTEP; i++) hi_tab[i] = 24'($urandom);

        // Reset, warmup, then the magnitude step.
        do_reset();
        out_log.delete();
        exp_log.delete();
        for (int i = 0; i < NSTEP; i++) begin
            step(1'b1, step_word(i));
            if (i == 254) check("warm_not_done", dbg_st, 0);
            if (i == 255) check("warm_done", dbg_st, 1);
        end
        check("burst_len", out_log.size(), 80);
        check("burst_trig", dbg_cnt, 1);
        if (out_log.size() > 0) check("pre_step_word", out_log[0][11:0], 50);
        seq_a = exp_log;

        // Sustained strong signal with a permissive threshold: holdoff spaces triggers.
        cfg_thr = 16'h0080;
        for (int i = 0; i < 500; i++) step(1'b1, mk(24'($urandom), 500, 500));
        check("trig_multi", trig_log.size() >= 3, 1);
        for (int i = 1; i < trig_log.size(); i++)
            check("holdoff_gap", (trig_log[i] - trig_log[i-1]) >= 180, 1);

        // Clear at the 10th PASS output.
        out_log.delete();
        reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step(1'b1, mk(24'($urandom), 500, 500));
            if (out_log.size() == 10) begin
                reached = 1'b1;
                break;
            end
        end
        check("clr_reach", reached, 1);
        cfg_clr = 1'b1;
        step(1'b1, mk(24'($urandom), 500, 500));
        cfg_clr = 1'b0;
        check("clr_vld", fifo_out_wrreq, 0);
        check("clr_s", dbg_s, 0);
        check("clr_l", dbg_l, 0);
        cnt_before = dbg_cnt;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, mk(24'($urandom), 500, 500));
            if (i == 254) check("clr_warm", dbg_st, 0);
        end
        check("clr_no_trig", dbg_cnt, cnt_before);
        check("clr_rearm", dbg_st, 1);

        // Bypass with a ramp and some idle cycles.
        cfg_byp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step((i % 5) != 3, 48'h0A00_0000_0000 + 48'(i * 3));
            if ((i % 5) != 3) check("byp_word", fifo_out_wrdata, 48'h0A00_0000_0000 + 48'(i * 3));
        end
        cfg_byp = 1'b0;
        cfg_thr = 16'h0200;

        // Same step sequence with random input gaps.
        do_reset();
        cfg_len = 16'd64; cfg_hold = 16'd100; cfg_en = 1'b1;
        out_log.delete();
        idx = 0;
        for (int i = 0; i < 3000 && idx < NSTEP; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, step_word(idx));
                idx++;
            end else begin
                step(1'b0, 48'($urandom));
            end
        end
        check("gap_seq_done", idx, NSTEP);
        check("gap_seq_len", out_log.size(), seq_a.size());
        for (int i = 0; i < out_log.size() && i < seq_a.size(); i++)
            check("gap_seq_word", out_log[i], seq_a[i]);

        // Randomized segments: amplitude bursts, config churn, occasional clears.
        amp = 8;
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) begin
                amp      = ($urandom_range(0, 3) == 0) ? 2047 : int'($urandom_range(4, 60));
                cfg_thr  = ($urandom_range(0, 1) == 0) ? 16'h0200 : 16'($urandom_range(0, 16'h0600));
                cfg_len  = 16'($urandom_range(0, 40));
                cfg_hold = 16'($urandom_range(0, 30));
                cfg_en   = ($urandom_range(0, 4) != 0);
            end
            cfg_clr = ($urandom_range(0, 299) == 0);
            iv = int'($urandom_range(0, 2 * amp)) - amp;
            qv = int'($urandom_range(0, 2 * amp)) - amp;
            if ($urandom_range(0, 49) == 0) begin
                iv = -2048;
                qv = -2048;
            end
            step($urandom_range(0, 1) == 1, mk(24'($urandom), iv, qv));
        end
        cfg_clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
